// File: rtl/muldiv_sequencer.sv
// Purpose: multi-cycle signed MUL/DIV unit for the EX stage (radix-2 shift-add / restoring divide).
// Latency: accept at cycle N -> WIDTH CALC cycles, one FIX cycle, done strobe in cycle N+WIDTH+2.
// Backpressure: stalls the front of the pipe combinationally from accept through FIX; flush aborts.
module muldiv_sequencer #(
    parameter int          WIDTH    = 32,
    parameter logic [3:0]  MUL_CODE = 4'b0011,
    parameter logic [3:0]  DIV_CODE = 4'b0010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alucon,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]      CNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;   // sign of product / quotient
    logic               neg_hi_q, neg_hi_d;   // sign of remainder (div only)
    logic [WIDTH-1:0]   opnd_q, opnd_d;       // multiplicand or divisor magnitude
    logic [WIDTH:0]     acc_hi_q, acc_hi_d;   // upper product half / partial remainder
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;   // multiplier bits / quotient bits
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;

    logic               is_op;
    logic               accept;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   mul_add;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign is_op  = (alucon == MUL_CODE) || (alucon == DIV_CODE);
    assign accept = (state_q == IDLE) && start && !flush && is_op;

    // An unsigned WIDTH-bit magnitude is enough even for the most negative operand.
    assign mag_a = op_a[WIDTH-1] ? (~op_a + ONE_W) : op_a;
    assign mag_b = op_b[WIDTH-1] ? (~op_b + ONE_W) : op_b;

    // One shift-add step: conditional add into the upper half, carry shifts in at the top.
    assign mul_add = acc_lo_q[0] ? opnd_q : '0;
    assign mul_sum = acc_hi_q + {1'b0, mul_add};

    // One restoring-divide step: shift remainder left by one dividend bit, then trial subtract.
    assign div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]} - {2'b00, opnd_q};

    // Sign correction of the finished magnitudes.
    assign prod     = {acc_hi_q[WIDTH-1:0], acc_lo_q};
    assign prod_fix = neg_lo_q ? (~prod + ONE_2W) : prod;
    assign quot_fix = neg_lo_q ? (~acc_lo_q + ONE_W) : acc_lo_q;
    assign rem_fix  = neg_hi_q ? (~acc_hi_q[WIDTH-1:0] + ONE_W) : acc_hi_q[WIDTH-1:0];

    // State and datapath registers; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
        end
    end

    // Next-state: flush aborts CALC/FIX, DONE always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (flush) state_d = IDLE;
                     else if (cnt_q == '0) state_d = FIX;
            FIX:     state_d = flush ? IDLE : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate in CALC, sign-fix and publish lo/hi in FIX.
    always_comb begin
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    is_div_d = (alucon == DIV_CODE);
                    neg_lo_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                    neg_hi_d = (alucon == DIV_CODE) ? op_a[WIDTH-1]
                                                    : (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    opnd_d   = (alucon == DIV_CODE) ? mag_b : mag_a;
                    acc_lo_d = (alucon == DIV_CODE) ? mag_a : mag_b;
                    acc_hi_d = '0;
                    cnt_d    = CNT_INIT;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    if (!div_trial[WIDTH+1]) begin
                        acc_hi_d = div_trial[WIDTH:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = {1'b0, mul_sum[WIDTH:1]};
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
            end
            FIX: begin
                if (!flush) begin
                    if (is_div_q) begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end else begin
                        lo_d = prod_fix[WIDTH-1:0];
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs: stall covers the accept cycle through FIX; DONE releases the pipe.
    always_comb begin
        stall = accept || (state_q == CALC) || (state_q == FIX);
        busy  = (state_q != IDLE);
        done  = (state_q == DONE);
    end

    assign lo = lo_q;
    assign hi = hi_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed corner cases plus random MUL/DIV traffic.
// Expected results come from plain signed 64-bit arithmetic on the operands.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_muldiv_sequencer;

    localparam logic [3:0] MUL = 4'b0011;
    localparam logic [3:0] DIV = 4'b0010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  alucon = 4'b0000;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        stall, busy, done;
    logic [31:0] lo, hi;

    int checks = 0;
    int failures = 0;
    logic [31:0] prev_lo = '0;
    logic [31:0] prev_hi = '0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(32), .MUL_CODE(MUL), .DIV_CODE(DIV)) dut (
        .clk(clk), .reset(reset), .start(start), .alucon(alucon),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .lo(lo), .hi(hi)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed arithmetic; C-style truncating division, remainder takes dividend sign.
    function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] elo, output logic [31:0] ehi);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        elo = '0;
        ehi = '0;
        if (!is_div) begin
            p = sa * sb;
            elo = p[31:0];
            ehi = p[63:32];
        end else if (b != 32'd0) begin
            q = sa / sb;
            r = sa % sb;
            elo = q[31:0];
            ehi = r[31:0];
        end
    endfunction

    // Present one op and hold start until done; chain leaves start asserted for the next op.
    task automatic run_op(input string tag, input logic [3:0] code, input logic [31:0] a,
                          input logic [31:0] b, input bit check_vals, input bit chain);
        logic [31:0] elo, ehi;
        int done_at;
        int stall_cycles;
        int done_cnt;
        model(code == DIV, a, b, elo, ehi);
        @(posedge clk); #1;
        start = 1'b1; alucon = code; op_a = a; op_b = b; flush = 1'b0;
        @(negedge clk);
        chk({tag, ".accept_stall"}, 64'(stall), 64'd1);
        chk({tag, ".accept_done"}, 64'(done), 64'd0);
        done_at = -1;
        stall_cycles = 1;
        done_cnt = 0;
        for (int k = 1; k <= 40 && done_at < 0; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (stall === 1'b1) stall_cycles++;
            if (done === 1'b1) begin
                done_at = k;
                done_cnt++;
            end
        end
        chk({tag, ".done_latency"}, 64'(done_at), 64'd34);
        chk({tag, ".stall_cycles"}, 64'(stall_cycles), 64'd34);
        if (check_vals) begin
            chk({tag, ".lo"}, 64'(lo), 64'(elo));
            chk({tag, ".hi"}, 64'(hi), 64'(ehi));
            prev_lo = elo;
            prev_hi = ehi;
        end else begin
            chk({tag, ".no_x"}, 64'($isunknown({lo, hi})), 64'd0);
        end
        if (!chain) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk({tag, ".after_done"}, 64'(done), 64'd0);
            chk({tag, ".after_busy"}, 64'(busy), 64'd0);
            if (check_vals) chk({tag, ".lo_hold"}, 64'(lo), 64'(prev_lo));
        end
    endtask

    // Start a 100/7 divide, then abort it with flush or reset during its 10th cycle.
    task automatic abort_op(input string tag, input bit use_reset);
        int done_cnt;
        @(posedge clk); #1;
        start = 1'b1; alucon = DIV; op_a = 32'd100; op_b = 32'd7;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 10) begin
                if (use_reset) reset = 1'b1;
                else flush = 1'b1;
            end
        end
        @(negedge clk);
        chk({tag, ".busy_at_abort"}, 64'(busy), use_reset ? 64'd1 : 64'd1);
        @(posedge clk); #1;
        reset = 1'b0; flush = 1'b0; start = 1'b0;
        @(negedge clk);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".stall"}, 64'(stall), 64'd0);
        if (use_reset) begin
            prev_lo = '0;
            prev_hi = '0;
        end
        chk({tag, ".lo"}, 64'(lo), 64'(prev_lo));
        chk({tag, ".hi"}, 64'(hi), 64'(prev_hi));
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done !== 1'b0) done_cnt++;
        end
        chk({tag, ".no_done"}, 64'(done_cnt), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  rc;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.stall", 64'(stall), 64'd0);
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.lo", 64'(lo), 64'd0);
        chk("reset.hi", 64'(hi), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed arithmetic
        run_op("mul_7_m3", MUL, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0);
        chk("mul_7_m3.lo_const", 64'(lo), 64'hFFFF_FFEB);
        run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        chk("div_m7_2.lo_const", 64'(lo), 64'hFFFF_FFFD);
        run_op("div_100_7", DIV, 32'd100, 32'd7, 1'b1, 1'b0);

        // Non-mul/div code passes through
        @(posedge clk); #1;
        start = 1'b1; alucon = 4'b0000; op_a = 32'd5; op_b = 32'd6;
        @(negedge clk);
        chk("nonop.stall", 64'(stall), 64'd0);
        chk("nonop.busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("nonop.busy2", 64'(busy), 64'd0);
        chk("nonop.lo", 64'(lo), 64'(prev_lo));
        chk("nonop.hi", 64'(hi), 64'(prev_hi));
        start = 1'b0;

        // Most-negative operands
        run_op("mul_min_min", MUL, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        chk("mul_min_min.hi_const", 64'(hi), 64'h4000_0000);
        run_op("div_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        chk("div_min_m1.lo_const", 64'(lo), 64'h8000_0000);

        // Flush in IDLE suppresses accept
        @(posedge clk); #1;
        start = 1'b1; alucon = MUL; op_a = 32'd3; op_b = 32'd3; flush = 1'b1;
        @(negedge clk);
        chk("idle_flush.stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("idle_flush.busy", 64'(busy), 64'd0);

        // Aborts mid-divide
        abort_op("flush_abort", 1'b0);
        abort_op("reset_abort", 1'b1);

        // Back-to-back: held mul through DONE, div presented the cycle after
        run_op("b2b_mul", MUL, 32'hFFFF_FF00, 32'd1234, 1'b1, 1'b1);
        run_op("b2b_div", DIV, 32'd1000, 32'hFFFF_FFF3, 1'b1, 1'b0);

        // Divide by zero: latency and no X only
        run_op("div_zero", DIV, 32'h1234_5678, 32'd0, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 10; i++) begin
            rc = ($urandom_range(0, 1) == 1) ? DIV : MUL;
            if (i % 3 == 0) begin
                ra = $urandom;
                rb = $urandom;
            end else begin
                ra = 32'($urandom_range(0, 200)) - 32'd100;
                rb = 32'($urandom_range(0, 40)) - 32'd20;
            end
            if (rc == DIV && rb == 32'd0) rb = 32'd1;
            run_op("rand", rc, ra, rb, 1'b1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
